// File: rtl/risc_pkg.sv
// Shared definitions for the execute sequencer: control-word bit positions,
// sequencer state encoding, PC select codes and datapath widths.
// Ports: none (package).
package risc_pkg;

  localparam int CTRL_W = 25;
  localparam int PC_W   = 32;
  localparam int REG_W  = 5;
  localparam int OFF_W  = 16;

  // Decoded control word layout
  localparam int RS_MSB         = 24;
  localparam int RS_LSB         = 20;
  localparam int RT_MSB         = 19;
  localparam int RT_LSB         = 15;
  localparam int RD_MSB         = 14;
  localparam int RD_LSB         = 10;
  localparam int BIT_WR_REGFILE = 9;
  localparam int BIT_IMM_B      = 8;
  localparam int ALU_SEL_MSB    = 7;
  localparam int ALU_SEL_LSB    = 6;
  localparam int BIT_MUL_START  = 5;
  localparam int BIT_MUX2_ALU   = 4;
  localparam int BIT_WR_MEM     = 3;
  localparam int BIT_CS_WB      = 2;
  localparam int BIT_BRANCH     = 1;
  localparam int BIT_JMP        = 0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EXEC     = 3'd1,
    S_MUL_WAIT = 3'd2,
    S_MEM      = 3'd3,
    S_WB       = 3'd4
  } seq_state_t;

  typedef enum logic [1:0] {
    PC_INC    = 2'd0,
    PC_JMP    = 2'd1,
    PC_BRANCH = 2'd2
  } pc_sel_t;

  function automatic logic [PC_W-1:0] sext_offset(input logic [OFF_W-1:0] off);
    return {{(PC_W-OFF_W){off[OFF_W-1]}}, off};
  endfunction

endpackage

// File: rtl/exec_pc_unit.sv
// Program counter register with next-PC select (increment, jump, bne target).
// Ports: clk/rst, update (load next PC), sel, jmp_address, branch_offset -> pc.
// Branch target is pc+1+sext(offset); all arithmetic wraps modulo 2^32.
module exec_pc_unit
  import risc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              update,
  input  pc_sel_t           sel,
  input  logic [PC_W-1:0]   jmp_address,
  input  logic [OFF_W-1:0]  branch_offset,
  output logic [PC_W-1:0]   pc
);

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_next;

  assign pc_inc = pc + 32'd1;

  always_comb begin
    pc_next = pc_inc;
    unique case (sel)
      PC_JMP:    pc_next = jmp_address;
      PC_BRANCH: pc_next = pc_inc + sext_offset(branch_offset);
      default:   pc_next = pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (update) begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle issue sequencer: holds one control word, pulses mul/mem/regfile strobes.
// Latency: ALU 3 cycles accept-to-ready, load 4, store 3, jmp/bne 2, mul until mul_done+2.
// Backpressure: ctrl_ready only in IDLE; front end stalls while an instruction is in flight.
// Ports: ctrl_word/jmp_address/branch_offset/ctrl_valid/ctrl_ready in; alu_zero, mul_done
// status in; exec_ctrl, mul_start, mem_we, regfile_we, wb_rd, pc, mul_timeout_err out.
// Optional macro EXEC_SEQ_MUL_TIMEOUT_EN adds a MUL_WAIT watchdog (abort after MUL_TIMEOUT).
module exec_sequencer
  import risc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = 32'd0,
  parameter int unsigned     MUL_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl_word,
  input  logic [PC_W-1:0]   jmp_address,
  input  logic [OFF_W-1:0]  branch_offset,
  input  logic              ctrl_valid,
  output logic              ctrl_ready,
  input  logic              alu_zero,
  input  logic              mul_done,
  output logic [CTRL_W-1:0] exec_ctrl,
  output logic              mul_start,
  output logic              mem_we,
  output logic              regfile_we,
  output logic [REG_W-1:0]  wb_rd,
  output logic [PC_W-1:0]   pc,
  output logic              mul_timeout_err
);

  if (MUL_TIMEOUT < 1) begin : g_bad_timeout
    $error("MUL_TIMEOUT must be at least 1");
  end

  seq_state_t        state, state_n;
  logic [CTRL_W-1:0] word_q;
  logic [PC_W-1:0]   jmp_q;
  logic [OFF_W-1:0]  off_q;
  logic [REG_W-1:0]  rd_q;
  logic              accept;
  logic              pc_update;
  pc_sel_t           pc_sel;

  // Instruction class, priority jmp > branch > mul > mem > writeback
  logic plain_op, cls_jmp, cls_br, cls_mul, cls_store, cls_wb, cls_load;

  assign accept    = (state == S_IDLE) && ctrl_valid;
  assign plain_op  = !word_q[BIT_JMP] && !word_q[BIT_BRANCH] && !word_q[BIT_MUL_START];
  assign cls_jmp   = word_q[BIT_JMP];
  assign cls_br    = !word_q[BIT_JMP] && word_q[BIT_BRANCH];
  assign cls_mul   = !word_q[BIT_JMP] && !word_q[BIT_BRANCH] && word_q[BIT_MUL_START];
  assign cls_store = plain_op && word_q[BIT_WR_MEM];
  assign cls_wb    = plain_op && !word_q[BIT_WR_MEM] && word_q[BIT_WR_REGFILE];
  assign cls_load  = cls_wb && !word_q[BIT_CS_WB];

`ifdef EXEC_SEQ_MUL_TIMEOUT_EN
  localparam int CNT_W = $clog2(MUL_TIMEOUT + 1);
  logic [CNT_W-1:0] mul_cnt;
  logic             mul_expired;
  logic             timeout_hit;
  logic             err_q;

  // mul_cnt equals the number of cycles already spent in MUL_WAIT
  assign mul_expired = (mul_cnt == CNT_W'(MUL_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      mul_cnt <= (state == S_MUL_WAIT) ? mul_cnt + CNT_W'(1) : '0;
      if (timeout_hit) err_q <= 1'b1;
    end
  end

  assign mul_timeout_err = err_q;
`else
  assign mul_timeout_err = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    pc_update = 1'b0;
    pc_sel    = PC_INC;
`ifdef EXEC_SEQ_MUL_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (ctrl_valid) state_n = S_EXEC;
      end
      S_EXEC: begin
        if (cls_jmp) begin
          state_n   = S_IDLE;
          pc_update = 1'b1;
          pc_sel    = PC_JMP;
        end else if (cls_br) begin
          state_n   = S_IDLE;
          pc_update = 1'b1;
          pc_sel    = alu_zero ? PC_INC : PC_BRANCH;
        end else if (cls_mul) begin
          state_n = S_MUL_WAIT;
        end else if (cls_store || cls_load) begin
          state_n = S_MEM;
        end else if (cls_wb) begin
          state_n = S_WB;
        end else begin
          state_n   = S_IDLE;
          pc_update = 1'b1;
        end
      end
      S_MUL_WAIT: begin
        if (mul_done) begin
          state_n = S_WB;
        end
`ifdef EXEC_SEQ_MUL_TIMEOUT_EN
        else if (mul_expired) begin
          state_n     = S_IDLE;
          pc_update   = 1'b1;
          timeout_hit = 1'b1;
        end
`endif
      end
      S_MEM: begin
        if (cls_store) begin
          state_n   = S_IDLE;
          pc_update = 1'b1;
        end else begin
          state_n = S_WB;
        end
      end
      S_WB: begin
        state_n   = S_IDLE;
        pc_update = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      word_q <= '0;
      jmp_q  <= '0;
      off_q  <= '0;
      rd_q   <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        word_q <= ctrl_word;
        jmp_q  <= jmp_address;
        off_q  <= branch_offset;
        rd_q   <= ctrl_word[RD_MSB:RD_LSB];
      end
    end
  end

  // Strobes decode the registered state; rst masks them so an abandoned
  // instruction never produces a write.
  assign ctrl_ready = (state == S_IDLE);
  assign mul_start  = !rst && (state == S_EXEC) && cls_mul;
  assign mem_we     = !rst && (state == S_MEM) && cls_store;
  assign regfile_we = !rst && (state == S_WB);
  assign wb_rd      = rd_q;

  always_comb begin
    exec_ctrl                 = word_q;
    exec_ctrl[BIT_WR_REGFILE] = regfile_we;
    exec_ctrl[BIT_MUL_START]  = mul_start;
    exec_ctrl[BIT_WR_MEM]     = mem_we;
  end

  exec_pc_unit #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk           (clk),
    .rst           (rst),
    .update        (pc_update),
    .sel           (pc_sel),
    .jmp_address   (jmp_q),
    .branch_offset (off_q),
    .pc            (pc)
  );

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: reset state, a table of single instructions
// with hand-computed strobe cycles and resulting pc, then multiply-wait and reset corners.
module tb_exec_sequencer;

  logic        clk;
  logic        rst;
  logic [24:0] ctrl_word;
  logic [31:0] jmp_address;
  logic [15:0] branch_offset;
  logic        ctrl_valid;
  logic        ctrl_ready;
  logic        alu_zero;
  logic        mul_done;
  logic [24:0] exec_ctrl;
  logic        mul_start;
  logic        mem_we;
  logic        regfile_we;
  logic [4:0]  wb_rd;
  logic [31:0] pc;
  logic        mul_timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int          MAXC = 40;
  localparam logic [24:0] STROBE_MASK = ~25'h000228;

  exec_sequencer #(
    .RESET_PC    (32'h10),
    .MUL_TIMEOUT (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ctrl_word       (ctrl_word),
    .jmp_address     (jmp_address),
    .branch_offset   (branch_offset),
    .ctrl_valid      (ctrl_valid),
    .ctrl_ready      (ctrl_ready),
    .alu_zero        (alu_zero),
    .mul_done        (mul_done),
    .exec_ctrl       (exec_ctrl),
    .mul_start       (mul_start),
    .mem_we          (mem_we),
    .regfile_we      (regfile_we),
    .wb_rd           (wb_rd),
    .pc              (pc),
    .mul_timeout_err (mul_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] word;
    logic [31:0] jaddr;
    logic [15:0] off;
    logic        zero;
    int          done_a;   // cycles in which mul_done is pulsed (-1 = never)
    int          done_b;
    int          exp_ready; // first cycle with ctrl_ready again
    int          exp_we;    // regfile_we cycle, -1 = none
    int          exp_mem;
    int          exp_mul;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vt[20];

  function automatic logic [24:0] w(input logic [4:0] rd, input logic [9:0] lo);
    return {5'd1, 5'd2, rd, lo};
  endfunction

  function automatic vec_t mk(input logic [24:0] word, input logic [31:0] ja,
                              input logic [15:0] off, input logic z, input int da,
                              input int db, input int er, input int ew, input int em,
                              input int emul, input logic [31:0] epc);
    vec_t v;
    v.word = word; v.jaddr = ja; v.off = off; v.zero = z;
    v.done_a = da; v.done_b = db; v.exp_ready = er; v.exp_we = ew;
    v.exp_mem = em; v.exp_mul = emul; v.exp_pc = epc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction in the current (IDLE) cycle and trace it until ready.
  task automatic run_vec(input vec_t v, input string tag);
    int ready_c, we_c, mem_c, mul_c, we_n, mem_n, mul_n;
    logic stable;
    ready_c = -1; we_c = -1; mem_c = -1; mul_c = -1;
    we_n = 0; mem_n = 0; mul_n = 0; stable = 1'b1;
    check({tag, " ready_at_issue"}, 32'(ctrl_ready), 32'd1);
    ctrl_word = v.word; jmp_address = v.jaddr; branch_offset = v.off;
    alu_zero = v.zero; ctrl_valid = 1'b1; mul_done = 1'b0;
    for (int c = 1; c <= MAXC; c++) begin
      step();
      ctrl_valid = 1'b0;
      ctrl_word  = 25'h1FFFFFF;
      mul_done   = (c == v.done_a) || (c == v.done_b);
      if (regfile_we) begin we_n++;  if (we_c  < 0) we_c  = c; end
      if (mem_we)     begin mem_n++; if (mem_c < 0) mem_c = c; end
      if (mul_start)  begin mul_n++; if (mul_c < 0) mul_c = c; end
      if (ctrl_ready) begin
        ready_c = c;
        break;
      end
      if ((exec_ctrl & STROBE_MASK) !== (v.word & STROBE_MASK) ||
          exec_ctrl[9] !== regfile_we || exec_ctrl[5] !== mul_start ||
          exec_ctrl[3] !== mem_we)
        stable = 1'b0;
    end
    mul_done = 1'b0;
    check({tag, " ready_cycle"}, 32'(ready_c), 32'(v.exp_ready));
    check({tag, " we_cycle"},    32'(we_c),    32'(v.exp_we));
    check({tag, " we_count"},    32'(we_n),    (v.exp_we >= 0) ? 32'd1 : 32'd0);
    check({tag, " mem_cycle"},   32'(mem_c),   32'(v.exp_mem));
    check({tag, " mem_count"},   32'(mem_n),   (v.exp_mem >= 0) ? 32'd1 : 32'd0);
    check({tag, " mul_cycle"},   32'(mul_c),   32'(v.exp_mul));
    check({tag, " mul_count"},   32'(mul_n),   (v.exp_mul >= 0) ? 32'd1 : 32'd0);
    check({tag, " pc"},          pc,           v.exp_pc);
    check({tag, " wb_rd"},       32'(wb_rd),   32'(v.word[14:10]));
    check({tag, " exec_ctrl_stable"}, 32'(stable), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " pc"},         pc,                     32'h10);
    check({tag, " ready"},      32'(ctrl_ready),        32'd1);
    check({tag, " strobes"},    {29'd0, mul_start, mem_we, regfile_we}, 32'd0);
    check({tag, " exec_ctrl"},  32'(exec_ctrl),         32'd0);
    check({tag, " wb_rd"},      32'(wb_rd),             32'd0);
    check({tag, " err"},        32'(mul_timeout_err),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int we_n, ready_n, mul_n;
    rst = 1'b1; ctrl_word = '0; jmp_address = '0; branch_offset = '0;
    ctrl_valid = 1'b0; alu_zero = 1'b0; mul_done = 1'b0;

    //          word                  jaddr          off      z  da  db  rdy we mem mul pc
    vt[0]  = mk(w(0, 10'h001),        32'h0,         16'h0,    0, -1, -1, 2, -1, -1, -1, 32'h0);
    vt[1]  = mk(w(3, 10'h244),        32'h0,         16'h0,    0, -1, -1, 3,  2, -1, -1, 32'h1);
    vt[2]  = mk(w(4, 10'h304),        32'h0,         16'h0,    0, -1, -1, 3,  2, -1, -1, 32'h2);
    vt[3]  = mk(w(7, 10'h210),        32'h0,         16'h0,    0, -1, -1, 4,  3, -1, -1, 32'h3);
    vt[4]  = mk(w(0, 10'h018),        32'h0,         16'h0,    0, -1, -1, 3, -1,  2, -1, 32'h4);
    vt[5]  = mk(w(9, 10'h208),        32'h0,         16'h0,    0, -1, -1, 3, -1,  2, -1, 32'h5);
    vt[6]  = mk(w(0, 10'h001),        32'd20,        16'h0,    0, -1, -1, 2, -1, -1, -1, 32'd20);
    vt[7]  = mk(w(0, 10'h002),        32'h0,         16'hFFFC, 0, -1, -1, 2, -1, -1, -1, 32'd17);
    vt[8]  = mk(w(0, 10'h001),        32'd20,        16'h0,    0, -1, -1, 2, -1, -1, -1, 32'd20);
    vt[9]  = mk(w(0, 10'h002),        32'h0,         16'hFFFC, 1, -1, -1, 2, -1, -1, -1, 32'd21);
    vt[10] = mk(w(0, 10'h002),        32'h0,         16'h0003, 0, -1, -1, 2, -1, -1, -1, 32'd25);
    vt[11] = mk(w(5, 10'h220),        32'h0,         16'h0,    0, -1,  6, 8,  7, -1,  1, 32'd26);
    vt[12] = mk(w(6, 10'h020),        32'h0,         16'h0,    0,  1,  3, 5,  4, -1,  1, 32'd27);
    vt[13] = mk(w(0, 10'h000),        32'h0,         16'h0,    0, -1, -1, 2, -1, -1, -1, 32'd28);
    vt[14] = mk(w(0, 10'h021),        32'h40,        16'h0,    0, -1, -1, 2, -1, -1, -1, 32'h40);
    vt[15] = mk(w(0, 10'h008),        32'h0,         16'h0,    0, -1, -1, 3, -1,  2, -1, 32'h41);
    vt[16] = mk(w(0, 10'h001),        32'hFFFFFFFF,  16'h0,    0, -1, -1, 2, -1, -1, -1, 32'hFFFFFFFF);
    vt[17] = mk(w(31, 10'h204),       32'h0,         16'h0,    0, -1, -1, 3,  2, -1, -1, 32'h0);
    vt[18] = mk(w(0, 10'h003),        32'h40,        16'h0005, 0, -1, -1, 2, -1, -1, -1, 32'h40);
    vt[19] = mk(w(0, 10'h022),        32'h0,         16'h0005, 1, -1, -1, 2, -1, -1, -1, 32'h41);

    // Reset state
    step(); step();
    check_reset_state("reset_during");
    rst = 1'b0;
    step();
    check_reset_state("reset_after");

    for (int i = 0; i < 20; i++) run_vec(vt[i], $sformatf("v%0d", i));

`ifdef EXEC_SEQ_MUL_TIMEOUT_EN
    // Multiply with no mul_done: aborts after 8 MUL_WAIT cycles, pc+1, no writeback
    run_vec(mk(w(2, 10'h220), 32'h0, 16'h0, 0, -1, -1, 10, -1, -1, 1, 32'h42), "mul_timeout");
    check("mul_timeout err_set", 32'(mul_timeout_err), 32'd1);
    // Second hung multiply, reset while waiting
    ctrl_word = w(2, 10'h220); ctrl_valid = 1'b1;
    we_n = 0; mul_n = 0;
    for (int c = 1; c <= 4; c++) begin
      step();
      ctrl_valid = 1'b0;
      if (regfile_we) we_n++;
      if (mul_start) mul_n++;
    end
    check("timeout_sticky", 32'(mul_timeout_err), 32'd1);
`else
    // Without the watchdog the sequencer waits for mul_done indefinitely
    ctrl_word = w(2, 10'h220); ctrl_valid = 1'b1;
    we_n = 0; ready_n = 0; mul_n = 0;
    for (int c = 1; c <= 30; c++) begin
      step();
      ctrl_valid = 1'b0;
      if (regfile_we) we_n++;
      if (ctrl_ready) ready_n++;
      if (mul_start) mul_n++;
    end
    check("mul_hang ready_never", 32'(ready_n), 32'd0);
    check("mul_hang err", 32'(mul_timeout_err), 32'd0);
    check("mul_hang pc", pc, 32'h41);
`endif
    rst = 1'b1;
    step();
    if (regfile_we) we_n++;
    rst = 1'b0;
    step();
    if (regfile_we) we_n++;
    check("mul_wait_reset we_count", 32'(we_n), 32'd0);
    check("mul_wait_reset mul_count", 32'(mul_n), 32'd1);
    check_reset_state("mul_wait_reset");

    // Reset while an ALU op is in EXEC: its writeback must never happen
    ctrl_word = w(3, 10'h244); ctrl_valid = 1'b1;
    step();
    ctrl_valid = 1'b0;
    rst = 1'b1;
    step();
    check("exec_reset we_in_reset", 32'(regfile_we), 32'd0);
    rst = 1'b0;
    step();
    check("exec_reset we_after", 32'(regfile_we), 32'd0);
    check_reset_state("exec_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle issue sequencer between the instruction control decoder and the execute/memory/writeback datapath. It accepts one 25-bit decoded control word at a time, holds it stable for the datapath, and pulses the multiplier start, memory write and register-file write strobes in the correct cycles. It stalls the front end while an instruction is in flight and owns the program counter, including jump and branch-not-equal redirection.

## Interface
- RESET_PC, 32'd0, PC value after reset (word address)
- MUL_TIMEOUT, 64, max cycles in MUL_WAIT before abort (used only with watchdog)
- clk  in  1  system clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- ctrl_word  in  25  decoder output: rs[24:20], rt[19:15], rd[14:10], WR_regfile[9], mux_immediate_regB[8], ALU_sel[7:6], mul_start[5], mux2_ALU[4], WR_mem[3], CS_WB_2[2], branchFlag[1], jmpFlag[0]
- jmp_address  in  32  jump target from decoder
- branch_offset  in  16  signed word offset for bne
- ctrl_valid  in  1  ctrl_word/jmp_address/branch_offset valid
- ctrl_ready  out  1  sequencer can accept; transfer on valid&ready
- alu_zero  in  1  ALU result == 0
- mul_done  in  1  multiplier result ready
- exec_ctrl  out  25  latched word; bits 9, 5, 3 forced 0 except in their strobe cycle
- mul_start  out  1  one-cycle multiplier start
- mem_we  out  1  one-cycle data-memory write
- regfile_we  out  1  one-cycle register-file write
- wb_rd  out  5  latched destination register
- pc  out  32  current program counter
- mul_timeout_err  out  1  sticky watchdog error

## Operation
- States: IDLE, EXEC, MUL_WAIT, MEM, WB. ctrl_ready = 1 only in IDLE.
- Accept: in IDLE with ctrl_valid, latch word, jmp_address, branch_offset; go EXEC.
- Class by latched bits, priority jmp > branch > mul > mem > wb:
  - jmp: EXEC -> IDLE; pc <= jmp_address.
  - bne: EXEC samples alu_zero; taken if alu_zero==0: pc <= pc+1+sext(offset), else pc+1; -> IDLE.
  - mul (bit5): EXEC pulses mul_start -> MUL_WAIT until mul_done -> WB.
  - store (bit3): EXEC -> MEM pulses mem_we -> IDLE.
  - load (bit9 & bit2==0): EXEC -> MEM -> WB.
  - ALU/immediate (bit9 & bit2==1): EXEC -> WB.
  - none set: NOP, EXEC -> IDLE.
- WB pulses regfile_we, wb_rd = latched rd; -> IDLE.
- pc updates only on the transition into IDLE; non-redirect default pc+1; 32-bit wrap (0xFFFFFFFF+1 = 0).
- mul_done outside MUL_WAIT ignored.
- Reset: rst wins over all events; state IDLE, pc = RESET_PC, all strobes 0, exec_ctrl = 0, wb_rd = 0, mul_timeout_err = 0. Reset mid-instruction abandons it with no strobe.

## Timing
- Strobes and ctrl_ready are registered-state decodes, valid cycle after the transition.
- Accept at cycle 0: ALU op regfile_we in cycle 2, ready cycle 3; load regfile_we cycle 3; store mem_we cycle 2; jmp/bne ready cycle 2 with new pc.
- mul: mul_start cycle 1; mul_done seen in cycle n -> regfile_we cycle n+1.
- exec_ctrl stable from cycle 1 until return to IDLE.

## Configuration
- EXEC_SEQ_MUL_TIMEOUT_EN defined: counter in MUL_WAIT; after MUL_TIMEOUT cycles without mul_done, set mul_timeout_err (sticky until rst), go IDLE, pc+1, no writeback.
- Undefined: MUL_WAIT waits indefinitely; mul_timeout_err tied 0 (port kept).

## Structure
- Shared package risc_pkg: ctrl_word field bit-position constants, state encoding, width constants.
- One sub-module: exec_pc_unit (PC register, next-PC select, sign-extension).

## Test plan
- Reset, RESET_PC=0x10 -> pc=0x10, ctrl_ready=1, all strobes 0.
- Add word rd=3 at pc 0 -> regfile_we one cycle in cycle 2, wb_rd=3, pc=1, ready cycle 3.
- Mul, mul_done 5 cycles after mul_start -> single mul_start, regfile_we cycle after mul_done, pc+1.
- bne offset -4 at pc 20, alu_zero=0 -> pc=17; alu_zero=1 -> pc=21.
- Store then jmp to 0x40 -> one mem_we, no regfile_we, pc=0x40.
- Watchdog on, MUL_TIMEOUT=8, no mul_done -> err set after 8 cycles, no regfile_we, pc+1; rst mid-MUL_WAIT clears err, no strobe.
